// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared serializer state encoding and default width
package piso_serializer_pkg;

    // Shared with the downstream SIPO instantiation so both ends agree on word size
    localparam int DEFAULT_SER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with optional inter-word gap
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_SER_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_GAP   = ST_GAP;

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam bit            STREAM   = (GAP == 0);
    localparam bit            MSB      = (MSB_FIRST != 0);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_gap_cnt;

    logic             w_last;
    logic             w_ready;
    logic             w_hs;
    logic             w_end_bit;
    logic [WIDTH-1:0] w_shifted;

    // Last bit of the word is on the line; a new word may be taken here only when streaming
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
    assign w_ready   = !rst && ((r_state == S_IDLE) || (w_last && STREAM));
    assign w_hs      = load_valid && w_ready;

    // The output end of the shift register depends on bit order; shifting moves the next bit there
    assign w_end_bit = MSB ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shifted = MSB ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

    // Outputs come only from registered state so load_valid/pin never reach them combinationally
    assign sout       = (r_state == S_SHIFT) && w_end_bit;
    assign sout_valid = (r_state == S_SHIFT);
    assign word_done  = w_last;
    assign load_ready = w_ready;

    // Transmit FSM: load on handshake, shift one bit per clock, then optional idle gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_shreg <= pin;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (w_hs) begin
                            r_shreg <= pin;
                        end else begin
                            r_shreg   <= w_shifted;
                            r_gap_cnt <= '0;
                            r_state   <= STREAM ? S_IDLE : S_GAP;
                        end
                    end else begin
                        r_shreg <= w_shifted;
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed vector table plus randomized queue-model check
module tb_piso_serializer;

    localparam int NI = 4;
    localparam int WD[NI] = '{4, 4, 4, 8};
    localparam int MF[NI] = '{1, 1, 0, 1};
    localparam int GP[NI] = '{0, 2, 0, 0};

    logic       clk = 1'b0;
    logic       rst [NI];
    logic [7:0] pin [NI];
    logic       lv  [NI];
    logic       lr  [NI];
    logic       so  [NI];
    logic       sv  [NI];
    logic       wd  [NI];
    logic [3:0] sipo0 = 4'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) u0 (
        .clk(clk), .rst(rst[0]), .pin(pin[0][3:0]), .load_valid(lv[0]),
        .load_ready(lr[0]), .sout(so[0]), .sout_valid(sv[0]), .word_done(wd[0]));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP(2)) u1 (
        .clk(clk), .rst(rst[1]), .pin(pin[1][3:0]), .load_valid(lv[1]),
        .load_ready(lr[1]), .sout(so[1]), .sout_valid(sv[1]), .word_done(wd[1]));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .GAP(0)) u2 (
        .clk(clk), .rst(rst[2]), .pin(pin[2][3:0]), .load_valid(lv[2]),
        .load_ready(lr[2]), .sout(so[2]), .sout_valid(sv[2]), .word_done(wd[2]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u3 (
        .clk(clk), .rst(rst[3]), .pin(pin[3]), .load_valid(lv[3]),
        .load_ready(lr[3]), .sout(so[3]), .sout_valid(sv[3]), .word_done(wd[3]));

    // Reference downstream SIPO fed by instance 0
    always @(posedge clk) begin
        if (sv[0]) sipo0 <= {sipo0[2:0], so[0]};
    end

    typedef struct {
        int         inst;
        logic [7:0] pin;
        bit         lv;
        bit         rst;
        logic [3:0] exp;   // {sout, sout_valid, word_done, load_ready}
        bit         chk_sipo;
        string      nm;
    } row_t;

    row_t rows[$];

    task automatic add(input int inst, input logic [7:0] p, input bit v, input bit r,
                       input logic [3:0] e, input string nm, input bit cs = 1'b0);
        row_t x;
        x.inst = inst; x.pin = p; x.lv = v; x.rst = r; x.exp = e; x.chk_sipo = cs; x.nm = nm;
        rows.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] obs(input int k);
        return {so[k], sv[k], wd[k], lr[k]};
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b0;
            lv[k]  = 1'b0;
        end
    endtask

    // Behavioural model: a queue of bits still to be emitted plus remaining idle-gap cycles
    bit mq[NI][$];
    int mgap[NI];

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; lv[k] = 1'b0; pin[k] = 8'h00; mgap[k] = 0;
        end
        repeat (2) @(negedge clk);

        for (int k = 0; k < NI; k++) add(k, 8'h00, 0, 1, 4'b0000, "reset_state");

        // Single word 1011, MSB first
        add(0, 8'hB, 1, 0, 4'b0001, "t1_idle");
        add(0, 8'h0, 0, 0, 4'b1100, "t1_b0");
        add(0, 8'h0, 0, 0, 4'b0100, "t1_b1");
        add(0, 8'h0, 0, 0, 4'b1100, "t1_b2");
        add(0, 8'h0, 0, 0, 4'b1111, "t1_b3");
        add(0, 8'h0, 0, 0, 4'b0001, "t1_after", 1'b1);

        // Back-to-back A then 5 with no bubble
        add(0, 8'hA, 1, 0, 4'b0001, "t2_idle");
        add(0, 8'h5, 1, 0, 4'b1100, "t2_a0");
        add(0, 8'h5, 1, 0, 4'b0100, "t2_a1");
        add(0, 8'h5, 1, 0, 4'b1100, "t2_a2");
        add(0, 8'h5, 1, 0, 4'b0111, "t2_a3");
        add(0, 8'h0, 0, 0, 4'b0100, "t2_50");
        add(0, 8'h0, 0, 0, 4'b1100, "t2_51");
        add(0, 8'h0, 0, 0, 4'b0100, "t2_52");
        add(0, 8'h0, 0, 0, 4'b1111, "t2_53");
        add(0, 8'h0, 0, 0, 4'b0001, "t2_after");

        // GAP=2: F, two idle cycles, IDLE re-accept, then 0
        add(1, 8'hF, 1, 0, 4'b0001, "t3_idle");
        add(1, 8'h0, 1, 0, 4'b1100, "t3_f0");
        add(1, 8'h0, 1, 0, 4'b1100, "t3_f1");
        add(1, 8'h0, 1, 0, 4'b1100, "t3_f2");
        add(1, 8'h0, 1, 0, 4'b1110, "t3_f3");
        add(1, 8'h0, 1, 0, 4'b0000, "t3_gap0");
        add(1, 8'h0, 1, 0, 4'b0000, "t3_gap1");
        add(1, 8'h0, 1, 0, 4'b0001, "t3_reaccept");
        add(1, 8'h0, 0, 0, 4'b0100, "t3_00");
        add(1, 8'h0, 0, 0, 4'b0100, "t3_01");
        add(1, 8'h0, 0, 0, 4'b0100, "t3_02");
        add(1, 8'h0, 0, 0, 4'b0110, "t3_03");
        add(1, 8'h0, 0, 0, 4'b0000, "t3_gap2");
        add(1, 8'h0, 0, 0, 4'b0000, "t3_gap3");
        add(1, 8'h0, 0, 0, 4'b0001, "t3_idle2");

        // LSB first, 0001
        add(2, 8'h1, 1, 0, 4'b0001, "t4_idle");
        add(2, 8'h0, 0, 0, 4'b1100, "t4_b0");
        add(2, 8'h0, 0, 0, 4'b0100, "t4_b1");
        add(2, 8'h0, 0, 0, 4'b0100, "t4_b2");
        add(2, 8'h0, 0, 0, 4'b0111, "t4_b3");
        add(2, 8'h0, 0, 0, 4'b0001, "t4_after");

        // WIDTH=8 C3 with pin changing and a stray load_valid pulse mid-word
        add(3, 8'hC3, 1, 0, 4'b0001, "t6_idle");
        add(3, 8'h00, 0, 0, 4'b1100, "t6_b0");
        add(3, 8'h00, 1, 0, 4'b1100, "t6_b1");
        add(3, 8'h00, 0, 0, 4'b0100, "t6_b2");
        add(3, 8'h00, 0, 0, 4'b0100, "t6_b3");
        add(3, 8'h00, 0, 0, 4'b0100, "t6_b4");
        add(3, 8'h00, 0, 0, 4'b0100, "t6_b5");
        add(3, 8'h00, 0, 0, 4'b1100, "t6_b6");
        add(3, 8'h00, 0, 0, 4'b1111, "t6_b7");
        add(3, 8'h00, 0, 0, 4'b0001, "t6_after");

        foreach (rows[i]) begin
            @(negedge clk);
            clear_inputs();
            rst[rows[i].inst] = rows[i].rst;
            lv[rows[i].inst]  = rows[i].lv;
            pin[rows[i].inst] = rows[i].pin;
            #1;
            chk(rows[i].nm, 32'(obs(rows[i].inst)), 32'(rows[i].exp));
            if (rows[i].chk_sipo) chk("t1_sipo_pout", 32'(sipo0), 32'hB);
        end

        // Reset pulse mid-way through the 2nd bit of C, then 9 must go out cleanly
        @(negedge clk); clear_inputs(); pin[0] = 8'hC; lv[0] = 1'b1;
        #1 chk("t5_idle", 32'(obs(0)), 32'b0001);
        @(negedge clk); lv[0] = 1'b0;
        #1 chk("t5_c0", 32'(obs(0)), 32'b1100);
        @(negedge clk);
        #1 chk("t5_c1", 32'(obs(0)), 32'b1100);
        #2 rst[0] = 1'b1;
        #1 chk("t5_rst_immediate", 32'(obs(0)), 32'b0000);
        @(negedge clk); rst[0] = 1'b0; pin[0] = 8'h9; lv[0] = 1'b1;
        #1 chk("t5_ready_after_release", 32'(obs(0)), 32'b0001);
        @(negedge clk); lv[0] = 1'b0;
        #1 chk("t5_90", 32'(obs(0)), 32'b1100);
        @(negedge clk);
        #1 chk("t5_91", 32'(obs(0)), 32'b0100);
        @(negedge clk);
        #1 chk("t5_92", 32'(obs(0)), 32'b0100);
        @(negedge clk);
        #1 chk("t5_93", 32'(obs(0)), 32'b1111);
        @(negedge clk);
        #1 chk("t5_after", 32'(obs(0)), 32'b0001);

        // Randomized run on all instances against the queue model
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin rst[k] = 1'b1; lv[k] = 1'b0; end
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit r_now [NI];
            for (int k = 0; k < NI; k++) begin
                r_now[k] = ($urandom_range(0, 99) == 0);
                rst[k]   = r_now[k];
                lv[k]    = ($urandom_range(0, 2) != 0);
                pin[k]   = 8'($urandom);
            end
            #1;
            for (int k = 0; k < NI; k++) begin
                bit e_sv, e_so, e_wd, e_lr, hs, was_busy;
                if (r_now[k]) begin
                    chk($sformatf("rnd_rst_i%0d_c%0d", k, cyc), 32'(obs(k)), 32'h0);
                    mq[k].delete();
                    mgap[k] = 0;
                end else begin
                    e_sv = (mq[k].size() > 0);
                    e_so = e_sv ? mq[k][0] : 1'b0;
                    e_wd = (mq[k].size() == 1);
                    e_lr = ((mq[k].size() == 0) && (mgap[k] == 0)) ||
                           ((mq[k].size() == 1) && (GP[k] == 0));
                    chk($sformatf("rnd_i%0d_c%0d", k, cyc), 32'(obs(k)),
                        32'({e_so, e_sv, e_wd, e_lr}));
                    hs = lv[k] && e_lr;
                    was_busy = e_sv;
                    if (was_busy) begin
                        void'(mq[k].pop_front());
                        if (mq[k].size() == 0 && !hs && GP[k] > 0) mgap[k] = GP[k];
                    end else if (mgap[k] > 0) begin
                        mgap[k]--;
                    end
                    if (hs) begin
                        for (int b = 0; b < WD[k]; b++)
                            mq[k].push_back(MF[k] != 0 ? pin[k][WD[k] - 1 - b] : pin[k][b]);
                    end
                end
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
